// File: rtl/serial_word_assembler.sv
// Assembles a framed serial bit stream into N-bit words for the downstream enabled register.
// Completed words are presented with a one-cycle word_valid strobe; aborted frames pulse frame_err.
module serial_word_assembler #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         frame_start,
  output logic [N-1:0] word,
  output logic         word_valid,
  output logic         frame_err,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [N-1:0]   word_d;
  logic           word_valid_d;
  logic           frame_err_d;

  // Insert one bit so that the first bit of a frame ends up at the configured end of the word.
  function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[N-2:0], b};
    else           return {b, cur[N-1:1]};
  endfunction

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shift_d      = shift_q;
    word_d       = word;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sin_valid && frame_start) begin
          shift_d = shift_in('0, sin);
          count_d = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_start) begin
          // A frame_start inside a frame always aborts, even on what would have been bit N.
          frame_err_d = 1'b1;
          if (sin_valid) begin
            shift_d = shift_in('0, sin);
            count_d = CW'(1);
          end else begin
            shift_d = '0;
            count_d = '0;
            state_d = IDLE;
          end
        end else if (sin_valid) begin
          shift_d = shift_in(shift_q, sin);
          if (count_q == LAST_COUNT) begin
            word_d       = shift_d;
            word_valid_d = 1'b1;
            shift_d      = '0;
            count_d      = '0;
            state_d      = IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        shift_d = '0;
      end
    endcase
  end

  // busy is the registered view of the FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      shift_q    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      word       <= word_d;
      word_valid <= word_valid_d;
      frame_err  <= frame_err_d;
      busy       <= (state_d == SHIFT);
    end
  end

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler: one MSB-first and one LSB-first instance share the same stream;
// a small frame model pushes expected words and error pulses with their due cycle.
module tb_serial_word_assembler;

  logic       clk = 1'b0;
  logic       reset;
  logic       sin, sin_valid, frame_start;
  logic [7:0] word_m, word_l;
  logic       word_valid_m, word_valid_l;
  logic       frame_err_m, frame_err_l;
  logic       busy_m, busy_l;

  serial_word_assembler #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
    .word(word_m), .word_valid(word_valid_m), .frame_err(frame_err_m), .busy(busy_m)
  );

  serial_word_assembler #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
    .word(word_l), .word_valid(word_valid_l), .frame_err(frame_err_l), .busy(busy_l)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_m_q[$];
  logic [7:0] exp_l_q[$];
  int due_m_q[$];
  int due_l_q[$];
  int err_m_q[$];
  int err_l_q[$];
  int last_wv_m = 0;
  int prev_wv_m = 0;

  // frame model
  bit       m_busy = 1'b0;
  int       m_cnt  = 0;
  logic [7:0] m_acc = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic push_err();
    err_m_q.push_back(cyc + 1);
    err_l_q.push_back(cyc + 1);
  endtask

  // driver tasks: each waits for a falling edge, checks busy against the model, then drives
  task automatic drive_bit(input logic b, input logic fs);
    @(negedge clk);
    check_eq("busy_msb", busy_m, m_busy);
    check_eq("busy_lsb", busy_l, m_busy);
    sin = b; sin_valid = 1'b1; frame_start = fs;
    if (fs) begin
      if (m_busy) push_err();
      m_busy = 1'b1; m_cnt = 1; m_acc = {7'b0, b};
    end else if (m_busy) begin
      m_acc = {m_acc[6:0], b};
      m_cnt++;
      if (m_cnt == 8) begin
        exp_m_q.push_back(m_acc);       due_m_q.push_back(cyc + 1);
        exp_l_q.push_back(rev8(m_acc)); due_l_q.push_back(cyc + 1);
        m_busy = 1'b0; m_cnt = 0;
      end
    end
  endtask

  task automatic drive_idle();
    @(negedge clk);
    check_eq("busy_msb", busy_m, m_busy);
    check_eq("busy_lsb", busy_l, m_busy);
    sin = 1'($urandom_range(0, 1)); sin_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic drive_fs_only();
    @(negedge clk);
    sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b1;
    if (m_busy) push_err();
    m_busy = 1'b0; m_cnt = 0;
  endtask

  // sends bits first..last of v (v[7] goes first); bit 0 carries frame_start
  task automatic send_frame(input logic [7:0] v, input int max_gap, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (i > 0) repeat ($urandom_range(0, max_gap)) drive_idle();
      drive_bit(v[7-i], (i == 0));
    end
  endtask

  // monitor: compare every strobe against the expected queues at the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (word_valid_m || frame_err_m)
        check_eq("msb_exclusive", {31'b0, word_valid_m & frame_err_m}, 0);
      if (word_valid_m) begin
        prev_wv_m = last_wv_m; last_wv_m = cyc;
        if (exp_m_q.size() == 0) check_eq("msb_spurious_valid", 1, 0);
        else begin
          check_eq("msb_word", word_m, exp_m_q.pop_front());
          check_eq("msb_valid_cycle", cyc, due_m_q.pop_front());
        end
      end else if (due_m_q.size() > 0 && due_m_q[0] < cyc) begin
        check_eq("msb_missing_valid", 0, 1);
        void'(exp_m_q.pop_front()); void'(due_m_q.pop_front());
      end
      if (frame_err_m) begin
        if (err_m_q.size() == 0) check_eq("msb_spurious_err", 1, 0);
        else check_eq("msb_err_cycle", cyc, err_m_q.pop_front());
      end else if (err_m_q.size() > 0 && err_m_q[0] < cyc) begin
        check_eq("msb_missing_err", 0, 1);
        void'(err_m_q.pop_front());
      end

      if (word_valid_l) begin
        if (exp_l_q.size() == 0) check_eq("lsb_spurious_valid", 1, 0);
        else begin
          check_eq("lsb_word", word_l, exp_l_q.pop_front());
          check_eq("lsb_valid_cycle", cyc, due_l_q.pop_front());
        end
      end else if (due_l_q.size() > 0 && due_l_q[0] < cyc) begin
        check_eq("lsb_missing_valid", 0, 1);
        void'(exp_l_q.pop_front()); void'(due_l_q.pop_front());
      end
      if (frame_err_l) begin
        if (err_l_q.size() == 0) check_eq("lsb_spurious_err", 1, 0);
        else check_eq("lsb_err_cycle", cyc, err_l_q.pop_front());
      end else if (err_l_q.size() > 0 && err_l_q[0] < cyc) begin
        check_eq("lsb_missing_err", 0, 1);
        void'(err_l_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_word_m"}, word_m, 0);
    check_eq({tag, "_word_l"}, word_l, 0);
    check_eq({tag, "_ctl_m"}, {word_valid_m, frame_err_m, busy_m}, 0);
    check_eq({tag, "_ctl_l"}, {word_valid_l, frame_err_l, busy_l}, 0);
  endtask

  initial begin
    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // basic frame, no gaps
    send_frame(8'hD0, 0, 0, 7);
    drive_idle();
    check_eq("d0_word_msb", word_m, 8'hD0);
    check_eq("d0_word_lsb", word_l, 8'h0B);
    drive_idle();

    // abort after 4 bits, restart with 0x3C on the abort cycle
    send_frame(8'hA5, 0, 0, 3);
    send_frame(8'h3C, 0, 0, 0);
    @(posedge clk); #1;
    check_eq("abort_err", frame_err_m, 1);
    check_eq("abort_word_held", word_m, 8'hD0);
    check_eq("abort_busy", busy_m, 1);
    send_frame(8'h3C, 0, 1, 7);
    drive_idle();
    check_eq("3c_word_msb", word_m, 8'h3C);

    // unframed bits are ignored in IDLE
    repeat (5) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    drive_idle();
    check_eq("unframed_word", word_m, 8'h3C);

    // gaps between bits
    send_frame(8'hD0, 3, 0, 7);
    drive_idle();
    check_eq("gap_word_lsb", word_l, 8'h0B);
    for (int k = 0; k < 4; k++) begin
      send_frame(8'($urandom_range(0, 255)), 3, 0, 7);
      repeat ($urandom_range(0, 2)) drive_idle();
    end

    // abort on the cycle that would have supplied bit 8, then a frame_start-only abort
    send_frame(8'h81, 0, 0, 6);
    send_frame(8'h5A, 1, 0, 7);
    drive_idle();
    send_frame(8'h77, 0, 0, 2);
    drive_fs_only();
    repeat (2) drive_idle();

    // back-to-back frames
    send_frame(8'hFF, 0, 0, 7);
    send_frame(8'h01, 0, 0, 7);
    repeat (2) drive_idle();
    check_eq("b2b_spacing", last_wv_m - prev_wv_m, 8);
    check_eq("b2b_last_word", word_m, 8'h01);

    // asynchronous reset mid-frame
    send_frame(8'h55, 0, 0, 2);
    @(negedge clk); #2;
    reset = 1'b1; sin_valid = 1'b0; frame_start = 1'b0;
    #1;
    check_all_zero("midreset");
    m_busy = 1'b0; m_cnt = 0;
    exp_m_q.delete(); exp_l_q.delete(); due_m_q.delete(); due_l_q.delete();
    err_m_q.delete(); err_l_q.delete();
    @(negedge clk);
    reset = 1'b0;
    send_frame(8'h96, 1, 0, 7);
    repeat (3) drive_idle();
    check_eq("post_reset_word", word_m, 8'h96);

    check_eq("pending_msb", exp_m_q.size(), 0);
    check_eq("pending_lsb", exp_l_q.size(), 0);
    check_eq("pending_err", err_m_q.size() + err_l_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
